bnn_fc_classifier: RTL and testbench

//  Binary fully-connected classifier stage that sits directly downstream of the BWN conv layer.
//  - Captures the layer's 154-bit binary activation vector when that layer pulses its end flag.
//  - Computes an XNOR-popcount score per class against binary weights read from an external

---
 rtl/bnn_fc_classifier.sv | 124 ++++++++++++
 tb/tb_bnn_fc_classifier.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/bnn_fc_classifier.sv
// bnn_fc_classifier: binary FC stage, XNOR-popcount per class against a streamed weight ROM, arg-max out.
// Defining BNN_FC_BIAS_EN adds the iBIAS port and a signed per-class bias on every score.
module bnn_fc_classifier #(
   parameter int BL  = 154,
   parameter int CW  = 14,
   parameter int NCH = 11,
   parameter int NC  = 10,
   parameter int AW  = 7,
   parameter int CLW = 4,
   parameter int SW  = 8,
   parameter int BW  = 8
) (
   input  logic                  iCLK,
   input  logic                  iRSTn,
   input  logic                  iSTART,
   input  logic [BL-1:0]         iDATA,
   output logic [AW-1:0]         oW_ADDR,
   input  logic [CW-1:0]         iW_DATA,
`ifdef BNN_FC_BIAS_EN
   input  logic [NC*BW-1:0]      iBIAS,
   output logic signed [SW+1:0]  oSCORE,
`else
   output logic [SW-1:0]         oSCORE,
`endif
   output logic [CLW-1:0]        oCLASS,
   output logic                  oVALID,
   output logic                  oBUSY
);
   localparam int KW = $clog2(NCH);
`ifdef BNN_FC_BIAS_EN
   localparam int OW = SW + 2;
   localparam logic [OW-1:0] SMIN = {1'b1, {(OW-1){1'b0}}};
   logic signed [OW-1:0] score, best, upd_score;
   logic [BW-1:0] bias;
`else
   localparam int OW = SW;
   localparam logic [OW-1:0] SMIN = '0;
   logic [OW-1:0] score, best, upd_score;
`endif
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
   state_t state, state_nx;
   logic [BL-1:0] data;
   logic [KW-1:0] k0, k1, k2;
   logic [CLW-1:0] c0, c1, c2, best_cls, upd_cls;
   logic v1, v2, issued, upd;
   logic [CW-1:0] xn;
   logic [SW-1:0] acc, pop, sum;

   // Stage 1 tags the address on oW_ADDR, stage 2 tags the ROM word now on iW_DATA.
   always_comb begin
      xn = ~(data[int'(k2)*CW +: CW] ^ iW_DATA);
      pop = '0;
      for (int i = 0; i < CW; i++) pop = pop + SW'(xn[i]);
      sum = (k2 == '0 ? '0 : acc) + pop;
   end

`ifdef BNN_FC_BIAS_EN
   assign bias  = iBIAS[int'(c2)*BW +: BW];
   assign score = $signed({2'b00, sum}) + $signed({{(OW-BW){bias[BW-1]}}, bias});
`else
   assign score = sum;
`endif

   assign upd       = v2 && k2 == KW'(NCH-1) && (c2 == '0 || score > best);
   assign upd_score = upd ? score : best;
   assign upd_cls   = upd ? c2 : best_cls;

   always_ff @(posedge iCLK or negedge iRSTn)
      if (!iRSTn) state <= IDLE;
      else state <= state_nx;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = iSTART ? RUN : IDLE;
         RUN:     state_nx = (v1 && k1 == KW'(NCH-1) && c1 == CLW'(NC-1)) ? DRAIN : RUN;
         DRAIN:   state_nx = DONE;
         default: state_nx = IDLE;
      endcase
      oVALID = state == DONE;
      oBUSY  = state != IDLE;
   end

   always_ff @(posedge iCLK or negedge iRSTn)
      if (!iRSTn) begin
         data     <= '0;
         oW_ADDR  <= '0;
         {k0, k1, k2, c0, c1, c2} <= '0;
         {v1, v2, issued} <= '0;
         acc      <= '0;
         best     <= '0;
         best_cls <= '0;
         oSCORE   <= '0;
         oCLASS   <= '0;
      end else begin
         v1 <= 1'b0;
         v2 <= v1;
         k2 <= k1;
         c2 <= c1;
         if (state == IDLE && iSTART) begin
            data     <= iDATA;
            k0       <= '0;
            c0       <= '0;
            issued   <= 1'b0;
            best     <= SMIN;
            best_cls <= '0;
         end else if (state == RUN && !issued) begin
            oW_ADDR <= AW'(int'(c0)*NCH + int'(k0));
            v1      <= 1'b1;
            k1      <= k0;
            c1      <= c0;
            k0      <= k0 == KW'(NCH-1) ? '0 : k0 + KW'(1);
            c0      <= k0 == KW'(NCH-1) ? c0 + CLW'(1) : c0;
            issued  <= k0 == KW'(NCH-1) && c0 == CLW'(NC-1);
         end
         if (v2) acc <= sum;
         best     <= (state == IDLE && iSTART) ? SMIN : upd_score;
         best_cls <= (state == IDLE && iSTART) ? '0 : upd_cls;
         if (state == DRAIN) begin
            oSCORE <= upd_score;
            oCLASS <= upd_cls;
         end
      end
endmodule

// File: tb/tb_bnn_fc_classifier.sv
// tb_bnn_fc_classifier: table vectors, randomized runs against a whole-vector XNOR model,
// plus restart-ignore, mid-run reset and (with BNN_FC_BIAS_EN) bias sequences.
module tb_bnn_fc_classifier;
   localparam int BL = 154, CW = 14, NCH = 11, NC = 10, AW = 7, CLW = 4, SW = 8, BW = 8;

   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
   logic [BL-1:0] data = '0;
   logic [AW-1:0] w_addr;
   logic [CW-1:0] w_data = '0;
   logic [CLW-1:0] cls;
   logic valid, busy;
`ifdef BNN_FC_BIAS_EN
   logic [NC*BW-1:0] bias = '0;
   logic signed [SW+1:0] score;
`else
   logic [SW-1:0] score;
`endif
   logic [CW-1:0] rom [0:127];
   int npass = 0, ntot = 0, vcount = 0;
   int q_addr[$];

   typedef struct {
      logic [BL-1:0] d;
      int win;
      logic [CW-1:0] ww;
      logic [CW-1:0] ow;
      int alt;
      logic [CW-1:0] am;
      int ecls;
      int esc;
   } vec_t;
   vec_t tbl[3];

   bnn_fc_classifier dut (
      .iCLK(clk), .iRSTn(rst_n), .iSTART(start), .iDATA(data),
      .oW_ADDR(w_addr), .iW_DATA(w_data),
`ifdef BNN_FC_BIAS_EN
      .iBIAS(bias),
`endif
      .oSCORE(score), .oCLASS(cls), .oVALID(valid), .oBUSY(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) w_data <= rom[w_addr];
   always @(negedge clk) if (valid) vcount++;

   task automatic chk(input string name, input int act, input int exp);
      ntot++;
      if (act == exp) npass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Reference: score = matching bits of the whole vector against the class's concatenated rows.
   task automatic model(input logic [BL-1:0] d, output int ecls, output int esc);
      logic [BL-1:0] w;
      int s;
      ecls = 0;
      esc = 0;
      for (int c = 0; c < NC; c++) begin
         for (int k = 0; k < NCH; k++) w[k*CW +: CW] = rom[c*NCH + k];
         s = BL - $countones(d ^ w);
`ifdef BNN_FC_BIAS_EN
         s += int'($signed(bias[c*BW +: BW]));
`endif
         if (c == 0 || s > esc) begin
            esc = s;
            ecls = c;
         end
      end
   endtask

   task automatic set_rom(input vec_t v);
      for (int a = 0; a < 128; a++) rom[a] = (a / NCH == v.win) ? v.ww : v.ow;
      if (v.alt >= 0) begin
         for (int k = 0; k < NCH; k++) rom[v.alt*NCH + k] = v.ww;
         rom[v.alt*NCH] = v.ww ^ v.am;
      end
   endtask

   task automatic rand_rom();
      for (int a = 0; a < 128; a++) rom[a] = CW'($urandom);
   endtask

   function automatic logic [BL-1:0] rand_data();
      logic [BL-1:0] d;
      for (int i = 0; i < BL; i++) d[i] = 1'($urandom_range(0, 1));
      return d;
   endfunction

   task automatic run_one(input logic [BL-1:0] d, input int restart_at, input string tag, output int lat);
      logic busy_ok;
      q_addr.delete();
      @(negedge clk);
      data = d;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      data = ~d;
      lat = 0;
      busy_ok = 1'b1;
      while (!valid && lat < 300) begin
         if (!busy) busy_ok = 1'b0;
         q_addr.push_back(int'(w_addr));
         start = (lat == restart_at - 1);
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
      chk({tag, "_busy_run"}, int'(busy_ok), 1);
      chk({tag, "_busy_valid"}, int'(busy), 1);
   endtask

   task automatic check_run(input logic [BL-1:0] d, input int restart_at, input string tag);
      int lat, ecls, esc;
      model(d, ecls, esc);
      run_one(d, restart_at, tag, lat);
      chk({tag, "_latency"}, lat, 112);
      chk({tag, "_class"}, int'(cls), ecls);
      chk({tag, "_score"}, int'(score), esc);
      @(negedge clk);
      chk({tag, "_busy_after"}, int'(busy), 0);
   endtask

   initial begin
      logic [BL-1:0] d;
      int lat, v0, errs;
      int dq[$];
      d = {(BL/2){2'b10}};
      tbl[0] = '{d: {BL{1'b1}}, win: 3, ww: {CW{1'b1}}, ow: '0, alt: -1, am: '0, ecls: 3, esc: 154};
      tbl[1] = '{d: '0, win: 0, ww: '0, ow: '0, alt: -1, am: '0, ecls: 0, esc: 154};
      tbl[2] = '{d: d, win: 7, ww: 14'h2AAA, ow: 14'h1555, alt: 2, am: 14'h0007, ecls: 7, esc: 154};
      for (int a = 0; a < 128; a++) rom[a] = '0;

      repeat (3) @(negedge clk);
      chk("rst_valid", int'(valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_class", int'(cls), 0);
      chk("rst_score", int'(score), 0);
      chk("rst_addr", int'(w_addr), 0);
      rst_n = 1'b1;

      for (int i = 0; i < 3; i++) begin
         set_rom(tbl[i]);
         run_one(tbl[i].d, -1, $sformatf("vec%0d", i), lat);
         chk($sformatf("vec%0d_latency", i), lat, 112);
         chk($sformatf("vec%0d_class", i), int'(cls), tbl[i].ecls);
         chk($sformatf("vec%0d_score", i), int'(score), tbl[i].esc);
         @(negedge clk);
         chk($sformatf("vec%0d_busy_after", i), int'(busy), 0);
      end

      for (int i = 0; i < 6; i++) begin
         rand_rom();
         check_run(rand_data(), -1, $sformatf("rnd%0d", i));
      end

      rand_rom();
      v0 = vcount;
      check_run(rand_data(), 20, "restart");
      repeat (30) @(negedge clk);
      chk("restart_valid_count", vcount - v0, 1);
      foreach (q_addr[i]) if (dq.size() == 0 || dq[$] != q_addr[i]) dq.push_back(q_addr[i]);
      if (dq.size() > 0 && dq[0] != 0) void'(dq.pop_front());
      chk("restart_addr_count", dq.size(), 110);
      errs = 0;
      foreach (dq[i]) if (dq[i] != i) errs++;
      chk("restart_addr_order", errs, 0);

      rand_rom();
      d = rand_data();
      @(negedge clk);
      data = d;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (49) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_valid", int'(valid), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_class", int'(cls), 0);
      chk("abort_score", int'(score), 0);
      chk("abort_addr", int'(w_addr), 0);
      v0 = vcount;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (150) @(negedge clk);
      chk("abort_no_valid", vcount - v0, 0);
      check_run(d, -1, "fresh");

`ifdef BNN_FC_BIAS_EN
      rand_rom();
      for (int k = 0; k < NCH; k++) begin
         rom[1*NCH + k] = {CW{1'b1}};
         rom[5*NCH + k] = {CW{1'b1}};
      end
      rom[1*NCH] = 14'h3FF0;
      rom[5*NCH] = '0;
      for (int c = 0; c < NC; c++) bias[c*BW +: BW] = 8'h80;
      bias[1*BW +: BW] = 8'hEC;
      bias[5*BW +: BW] = 8'h05;
      run_one({BL{1'b1}}, -1, "bias", lat);
      chk("bias_latency", lat, 112);
      chk("bias_class", int'(cls), 5);
      chk("bias_score", int'(score), 145);
      @(negedge clk);
`endif

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end
endmodule
